// File: rtl/l1_mem_arb_if.sv
// Request/response bundle between the cache-side requesters, the L1 memory
// arbiter and the off-core memory port.
//   req_*       : packed per-requester request strobes and payloads
//   req_ack     : per-requester acceptance pulse
//   rsp_*       : per-requester response pulse plus the shared response line
//   mem_req_*   : single outstanding request towards memory
//   mem_rsp_*   : response from memory
//   hold        : flush sequencer request to stop issuing new grants
//   drained     : arbiter idle, nothing in flight
//   spurious_rsp: sticky flag for a memory response with nothing in flight
// Modport slave is the arbiter; modport master is the surrounding
// environment (requesters, memory and flush sequencer).
interface l1_mem_arb_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned TAG_W   = 2
);
    localparam int unsigned OP_W = 5;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_store_data;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*OP_W-1:0]   req_opcode;
    logic [NUM_REQ-1:0]        req_ack;

    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_load_data;
    logic [TAG_W-1:0]          rsp_tag;
    logic [OP_W-1:0]           rsp_opcode;

    logic                      mem_req_valid;
    logic [ADDR_W-1:0]         mem_req_addr;
    logic [DATA_W-1:0]         mem_req_store_data;
    logic [TAG_W-1:0]          mem_req_tag;
    logic [OP_W-1:0]           mem_req_opcode;
    logic [1:0]                mem_req_src;
    logic                      mem_req_ack;

    logic                      mem_rsp_valid;
    logic [DATA_W-1:0]         mem_rsp_load_data;
    logic [TAG_W-1:0]          mem_rsp_tag;
    logic [OP_W-1:0]           mem_rsp_opcode;

    logic                      hold;
    logic                      drained;
    logic                      spurious_rsp;

    modport slave (
        input  req_valid, req_addr, req_store_data, req_tag, req_opcode,
        output req_ack,
        output rsp_valid, rsp_load_data, rsp_tag, rsp_opcode,
        output mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_tag,
        output mem_req_opcode, mem_req_src,
        input  mem_req_ack,
        input  mem_rsp_valid, mem_rsp_load_data, mem_rsp_tag, mem_rsp_opcode,
        input  hold,
        output drained, spurious_rsp
    );

    modport master (
        output req_valid, req_addr, req_store_data, req_tag, req_opcode,
        input  req_ack,
        input  rsp_valid, rsp_load_data, rsp_tag, rsp_opcode,
        input  mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_tag,
        input  mem_req_opcode, mem_req_src,
        output mem_req_ack,
        output mem_rsp_valid, mem_rsp_load_data, mem_rsp_tag, mem_rsp_opcode,
        output hold,
        input  drained, spurious_rsp
    );
endinterface

// File: rtl/l1_mem_arb.sv
// Round-robin arbiter for the shared off-core memory port. Up to NUM_REQ
// requesters (0 = L1D, 1 = L1I, 2 = spare) post requests; one transaction is
// kept outstanding and its line-sized response is routed back to the owner.
// Ports:
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : l1_mem_arb_if.slave (requests, responses, memory port,
//             hold/drained handshake, spurious response flag)
module l1_mem_arb #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned TAG_W   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    l1_mem_arb_if.slave bus
);
    localparam int unsigned OP_W  = 5;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    state_t              r_state,          w_state_nxt;
    logic [NUM_REQ-1:0]  r_pending,        w_pending_nxt;
    logic [IDX_W-1:0]    r_last_gnt,       w_last_gnt_nxt;
    logic [IDX_W-1:0]    r_gnt,            w_gnt_nxt;
    logic [NUM_REQ-1:0]  r_req_ack,        w_req_ack_nxt;
    logic [NUM_REQ-1:0]  r_rsp_valid,      w_rsp_valid_nxt;
    logic [DATA_W-1:0]   r_rsp_load_data,  w_rsp_load_data_nxt;
    logic [TAG_W-1:0]    r_rsp_tag,        w_rsp_tag_nxt;
    logic [OP_W-1:0]     r_rsp_opcode,     w_rsp_opcode_nxt;
    logic                r_mem_req_valid,  w_mem_req_valid_nxt;
    logic [ADDR_W-1:0]   r_mem_req_addr,   w_mem_req_addr_nxt;
    logic [DATA_W-1:0]   r_mem_req_data,   w_mem_req_data_nxt;
    logic [TAG_W-1:0]    r_mem_req_tag,    w_mem_req_tag_nxt;
    logic [OP_W-1:0]     r_mem_req_opcode, w_mem_req_opcode_nxt;
    logic                r_drained,        w_drained_nxt;
    logic                r_spurious,       w_spurious_nxt;

    // Unpacked views of the per-requester payloads
    logic [ADDR_W-1:0] w_req_addr [NUM_REQ];
    logic [DATA_W-1:0] w_req_data [NUM_REQ];
    logic [TAG_W-1:0]  w_req_tag  [NUM_REQ];
    logic [OP_W-1:0]   w_req_op   [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_req_addr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
        assign w_req_data[g] = bus.req_store_data[g*DATA_W +: DATA_W];
        assign w_req_tag[g]  = bus.req_tag[g*TAG_W +: TAG_W];
        assign w_req_op[g]   = bus.req_opcode[g*OP_W +: OP_W];
    end

    // Round-robin pick: first requester above last_gnt, wrapping
    logic [NUM_REQ-1:0] w_req;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_sel;
    logic               w_sel_vld;

    always_comb begin
        w_req     = r_pending | bus.req_valid;
        w_idx     = '0;
        w_sel     = '0;
        w_sel_vld = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((32'(r_last_gnt) + k) % NUM_REQ);
            if (!w_sel_vld && w_req[w_idx]) begin
                w_sel     = w_idx;
                w_sel_vld = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= IDLE;
            r_pending        <= '0;
            r_last_gnt       <= IDX_W'(NUM_REQ - 1);
            r_gnt            <= '0;
            r_req_ack        <= '0;
            r_rsp_valid      <= '0;
            r_rsp_load_data  <= '0;
            r_rsp_tag        <= '0;
            r_rsp_opcode     <= '0;
            r_mem_req_valid  <= 1'b0;
            r_mem_req_addr   <= '0;
            r_mem_req_data   <= '0;
            r_mem_req_tag    <= '0;
            r_mem_req_opcode <= '0;
            r_drained        <= 1'b1;
            r_spurious       <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_pending        <= w_pending_nxt;
            r_last_gnt       <= w_last_gnt_nxt;
            r_gnt            <= w_gnt_nxt;
            r_req_ack        <= w_req_ack_nxt;
            r_rsp_valid      <= w_rsp_valid_nxt;
            r_rsp_load_data  <= w_rsp_load_data_nxt;
            r_rsp_tag        <= w_rsp_tag_nxt;
            r_rsp_opcode     <= w_rsp_opcode_nxt;
            r_mem_req_valid  <= w_mem_req_valid_nxt;
            r_mem_req_addr   <= w_mem_req_addr_nxt;
            r_mem_req_data   <= w_mem_req_data_nxt;
            r_mem_req_tag    <= w_mem_req_tag_nxt;
            r_mem_req_opcode <= w_mem_req_opcode_nxt;
            r_drained        <= w_drained_nxt;
            r_spurious       <= w_spurious_nxt;
        end
    end

    // Next-state and output logic
    logic [NUM_REQ-1:0] w_clr;

    always_comb begin
        w_state_nxt          = r_state;
        w_clr                = '0;
        w_last_gnt_nxt       = r_last_gnt;
        w_gnt_nxt            = r_gnt;
        w_req_ack_nxt        = '0;
        w_rsp_valid_nxt      = '0;
        w_rsp_load_data_nxt  = r_rsp_load_data;
        w_rsp_tag_nxt        = r_rsp_tag;
        w_rsp_opcode_nxt     = r_rsp_opcode;
        w_mem_req_valid_nxt  = r_mem_req_valid;
        w_mem_req_addr_nxt   = r_mem_req_addr;
        w_mem_req_data_nxt   = r_mem_req_data;
        w_mem_req_tag_nxt    = r_mem_req_tag;
        w_mem_req_opcode_nxt = r_mem_req_opcode;
        w_spurious_nxt       = r_spurious;

        unique case (r_state)
            IDLE: begin
                if (bus.mem_rsp_valid) begin
                    w_spurious_nxt = 1'b1;
                end
                if (!bus.hold && w_sel_vld) begin
                    w_gnt_nxt            = w_sel;
                    w_mem_req_valid_nxt  = 1'b1;
                    w_mem_req_addr_nxt   = w_req_addr[w_sel];
                    w_mem_req_data_nxt   = w_req_data[w_sel];
                    w_mem_req_tag_nxt    = w_req_tag[w_sel];
                    w_mem_req_opcode_nxt = w_req_op[w_sel];
                    w_state_nxt          = REQ;
                end
            end
            REQ: begin
                if (bus.mem_req_ack) begin
                    w_mem_req_valid_nxt  = 1'b0;
                    w_req_ack_nxt[r_gnt] = 1'b1;
                    w_clr[r_gnt]         = 1'b1;
                    w_last_gnt_nxt       = r_gnt;
                    // A response alongside the ack completes the transaction at once
                    if (bus.mem_rsp_valid) begin
                        w_rsp_valid_nxt[r_gnt] = 1'b1;
                        w_rsp_load_data_nxt    = bus.mem_rsp_load_data;
                        w_rsp_tag_nxt          = bus.mem_rsp_tag;
                        w_rsp_opcode_nxt       = bus.mem_rsp_opcode;
                        w_state_nxt            = IDLE;
                    end else begin
                        w_state_nxt = WAIT_RSP;
                    end
                end else if (bus.mem_rsp_valid) begin
                    w_spurious_nxt = 1'b1;
                end
            end
            WAIT_RSP: begin
                if (bus.mem_rsp_valid) begin
                    w_rsp_valid_nxt[r_gnt] = 1'b1;
                    w_rsp_load_data_nxt    = bus.mem_rsp_load_data;
                    w_rsp_tag_nxt          = bus.mem_rsp_tag;
                    w_rsp_opcode_nxt       = bus.mem_rsp_opcode;
                    w_state_nxt            = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // A new strobe wins over the ack clear so back-to-back requests queue
        w_pending_nxt = bus.req_valid | (r_pending & ~w_clr);
        w_drained_nxt = (w_state_nxt == IDLE);
    end

    assign bus.req_ack            = r_req_ack;
    assign bus.rsp_valid          = r_rsp_valid;
    assign bus.rsp_load_data      = r_rsp_load_data;
    assign bus.rsp_tag            = r_rsp_tag;
    assign bus.rsp_opcode         = r_rsp_opcode;
    assign bus.mem_req_valid      = r_mem_req_valid;
    assign bus.mem_req_addr       = r_mem_req_addr;
    assign bus.mem_req_store_data = r_mem_req_data;
    assign bus.mem_req_tag        = r_mem_req_tag;
    assign bus.mem_req_opcode     = r_mem_req_opcode;
    assign bus.mem_req_src        = r_gnt;
    assign bus.drained            = r_drained;
    assign bus.spurious_rsp       = r_spurious;

endmodule
